// File: rtl/ab_pkg.sv
// ab_pkg: shared types and constants for the 1A2B guess-side solver.
//   solver_state_t : top-level FSM states
//   digit_t        : one BCD digit
//   score_t        : A/B score pair, 3 bits each (0-4 in legal play)
//   fail_code_t    : reason reported on the fail_code output
//   FIRST_CAND / LAST_CAND : smallest and largest distinct-digit candidates
package ab_pkg;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
    } score_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WAIT_FB,
        S_SOLVED,
        S_FAIL
    } solver_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_NO_CAND = 2'd2,
        FC_TURNS   = 2'd3
    } fail_code_t;

    localparam logic [15:0] FIRST_CAND = 16'h0123;
    localparam logic [15:0] LAST_CAND  = 16'h9876;

endpackage

// File: rtl/ab_scorer.sv
// ab_scorer: combinational 1A2B scorer.
//   cand      in  16  BCD candidate, [15:12]=thousands
//   ref_guess in  16  BCD recorded guess
//   score     out     a = positions with equal digits,
//                     b = digit matches at differing positions
// With non-distinct candidates the b count may wrap; such candidates are
// rejected by the distinct-digit check in the top, so the value is unused.
module ab_scorer
    import ab_pkg::*;
(
    input  logic [15:0] cand,
    input  logic [15:0] ref_guess,
    output score_t      score
);

    digit_t     cd;
    digit_t     rd;
    logic [2:0] a_cnt;
    logic [2:0] b_cnt;

    always_comb begin
        a_cnt = '0;
        b_cnt = '0;
        cd    = '0;
        rd    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                cd = cand[4*i +: 4];
                rd = ref_guess[4*j +: 4];
                if (cd == rd) begin
                    if (i == j) a_cnt = a_cnt + 3'd1;
                    else        b_cnt = b_cnt + 3'd1;
                end
            end
        end
        score.a = a_cnt;
        score.b = b_cnt;
    end

endmodule

// File: rtl/ab_solver.sv
// ab_solver: automatic 1A2B codebreaker. Proposes the lexicographically
// smallest distinct-digit guess consistent with every recorded
// (guess, score) pair, one candidate evaluated per clock.
//   CLOCK_50    in   system clock
//   reset_n     in   asynchronous active-low reset
//   start       in   pulse, begins a game (idle/solved/fail only)
//   abort       in   pulse, returns to idle from any state
//   fb_valid    in   pulse, feedback fb_a/fb_b for the current guess
//   guess       out  BCD guess, [15:12]=thousands
//   guess_valid out  guess awaits feedback
//   busy        out  searching or waiting for feedback
//   turns       out  guesses issued this game
//   solved/fail out  terminal status, held
//   fail_code   out  0 none, 1 illegal feedback, 2 no candidate, 3 turns
module ab_solver
    import ab_pkg::*;
#(
    parameter int unsigned MAX_TURNS = 8
)
(
    input  logic                               CLOCK_50,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               fb_valid,
    input  logic [2:0]                         fb_a,
    input  logic [2:0]                         fb_b,
    output logic [15:0]                        guess,
    output logic                               guess_valid,
    output logic                               busy,
    output logic [$clog2(MAX_TURNS+1)-1:0]     turns,
    output logic                               solved,
    output logic                               fail,
    output logic [1:0]                         fail_code
);

    localparam int unsigned TW = $clog2(MAX_TURNS + 1);

    solver_state_t state_q, state_d;
    logic [15:0]   cand_q, cand_d;
    logic [15:0]   guess_q, guess_d;
    logic [TW-1:0] turns_q, turns_d;
    logic [TW-1:0] count_q, count_d;
    fail_code_t    fail_code_q, fail_code_d;
    logic [15:0]   hist_guess_q [MAX_TURNS];
    logic [15:0]   hist_guess_d [MAX_TURNS];
    score_t        hist_score_q [MAX_TURNS];
    score_t        hist_score_d [MAX_TURNS];

    score_t        cand_score   [MAX_TURNS];
    logic          hist_ok;
    logic          cand_distinct;
    logic          fb_illegal;

    // 4-digit BCD increment, 9 -> 0 with carry into the next digit.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        digit_t      d;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic digits_distinct(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = i + 1; j < 4; j++) begin
                if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    for (genvar k = 0; k < MAX_TURNS; k++) begin : g_score
        ab_scorer u_scorer (
            .cand      (cand_q),
            .ref_guess (hist_guess_q[k]),
            .score     (cand_score[k])
        );
    end

    // Entries at or beyond the history count are masked as passing.
    always_comb begin
        hist_ok = 1'b1;
        for (int unsigned k = 0; k < MAX_TURNS; k++) begin
            if ((TW'(k) < count_q) && (cand_score[k] != hist_score_q[k])) begin
                hist_ok = 1'b0;
            end
        end
    end

    assign cand_distinct = digits_distinct(cand_q);

    assign fb_illegal = (fb_a > 3'd4) ||
                        (({1'b0, fb_a} + {1'b0, fb_b}) > 4'd4) ||
                        ((fb_a == 3'd3) && (fb_b == 3'd1));

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        guess_d      = guess_q;
        turns_d      = turns_q;
        count_d      = count_q;
        fail_code_d  = fail_code_q;
        hist_guess_d = hist_guess_q;
        hist_score_d = hist_score_q;

        if (abort) begin
            state_d     = S_IDLE;
            cand_d      = FIRST_CAND;
            guess_d     = '0;
            turns_d     = '0;
            count_d     = '0;
            fail_code_d = FC_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_SOLVED, S_FAIL: begin
                    if (start) begin
                        state_d     = S_SEARCH;
                        cand_d      = FIRST_CAND;
                        turns_d     = '0;
                        count_d     = '0;
                        fail_code_d = FC_NONE;
                    end
                end

                S_SEARCH: begin
                    if (cand_distinct && hist_ok) begin
                        guess_d = cand_q;
                        turns_d = turns_q + TW'(1);
                        state_d = S_WAIT_FB;
                    end else if (cand_q == LAST_CAND) begin
                        fail_code_d = FC_NO_CAND;
                        state_d     = S_FAIL;
                    end else begin
                        cand_d = bcd_inc(cand_q);
                    end
                end

                S_WAIT_FB: begin
                    if (fb_valid) begin
                        if ((fb_a == 3'd4) && (fb_b == 3'd0)) begin
                            state_d = S_SOLVED;
                        end else if (fb_illegal) begin
                            fail_code_d = FC_ILLEGAL;
                            state_d     = S_FAIL;
                        end else begin
                            for (int unsigned k = 0; k < MAX_TURNS; k++) begin
                                if (TW'(k) == count_q) begin
                                    hist_guess_d[k] = guess_q;
                                    hist_score_d[k] = '{a: fb_a, b: fb_b};
                                end
                            end
                            count_d = count_q + TW'(1);
                            if (count_d == TW'(MAX_TURNS)) begin
                                fail_code_d = FC_TURNS;
                                state_d     = S_FAIL;
                            end else begin
                                // Every candidate below guess already fails an
                                // older entry, so the search resumes just past it.
                                cand_d  = bcd_inc(guess_q);
                                state_d = S_SEARCH;
                            end
                        end
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cand_q      <= FIRST_CAND;
            guess_q     <= '0;
            turns_q     <= '0;
            count_q     <= '0;
            fail_code_q <= FC_NONE;
            for (int unsigned k = 0; k < MAX_TURNS; k++) begin
                hist_guess_q[k] <= '0;
                hist_score_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            guess_q      <= guess_d;
            turns_q      <= turns_d;
            count_q      <= count_d;
            fail_code_q  <= fail_code_d;
            hist_guess_q <= hist_guess_d;
            hist_score_q <= hist_score_d;
        end
    end

    assign guess       = guess_q;
    assign guess_valid = (state_q == S_WAIT_FB);
    assign busy        = (state_q == S_SEARCH) || (state_q == S_WAIT_FB);
    assign turns       = turns_q;
    assign solved      = (state_q == S_SOLVED);
    assign fail        = (state_q == S_FAIL);
    assign fail_code   = fail_code_q;

endmodule

// File: tb/tb_ab_solver.sv
// tb_ab_solver: directed and randomized checks of ab_solver against a
// behavioural model that brute-forces the smallest consistent candidate
// over the integers 0..9999 using decimal arithmetic.
module tb_ab_solver;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic        fb_valid = 1'b0;
    logic [2:0]  fb_a     = '0;
    logic [2:0]  fb_b     = '0;
    logic [15:0] guess;
    logic        guess_valid;
    logic        busy;
    logic [3:0]  turns;
    logic        solved;
    logic        fail;
    logic [1:0]  fail_code;

    logic        s2_start    = 1'b0;
    logic        s2_abort    = 1'b0;
    logic        s2_fb_valid = 1'b0;
    logic [2:0]  s2_fb_a     = '0;
    logic [2:0]  s2_fb_b     = '0;
    logic [15:0] d2_guess;
    logic        d2_valid;
    logic        d2_busy;
    logic [1:0]  d2_turns;
    logic        d2_solved;
    logic        d2_fail;
    logic [1:0]  d2_fail_code;

    int tests    = 0;
    int failures = 0;

    int hg[$];
    int ha[$];
    int hb[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    ab_solver #(.MAX_TURNS(8)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .fb_valid    (fb_valid),
        .fb_a        (fb_a),
        .fb_b        (fb_b),
        .guess       (guess),
        .guess_valid (guess_valid),
        .busy        (busy),
        .turns       (turns),
        .solved      (solved),
        .fail        (fail),
        .fail_code   (fail_code)
    );

    ab_solver #(.MAX_TURNS(2)) dut2 (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .start       (s2_start),
        .abort       (s2_abort),
        .fb_valid    (s2_fb_valid),
        .fb_a        (s2_fb_a),
        .fb_b        (s2_fb_b),
        .guess       (d2_guess),
        .guess_valid (d2_valid),
        .busy        (d2_busy),
        .turns       (d2_turns),
        .solved      (d2_solved),
        .fail        (d2_fail),
        .fail_code   (d2_fail_code)
    );

    // ---------------- reference model ----------------
    function automatic int dig(input int v, input int p);
        int r;
        r = v;
        for (int i = 0; i < p; i++) r = r / 10;
        return r % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int p = 0; p < 4; p++) r[4*p +: 4] = 4'(dig(v, p));
        return r;
    endfunction

    function automatic bit distinct(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (dig(v, i) == dig(v, j)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void score(input int x, input int y, output int a, output int b);
        a = 0;
        b = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (dig(x, i) == dig(y, j)) begin
                    if (i == j) a++;
                    else        b++;
                end
    endfunction

    function automatic int model_next();
        int a;
        int b;
        bit ok;
        for (int c = 0; c <= 9999; c++) begin
            if (distinct(c)) begin
                ok = 1'b1;
                foreach (hg[k]) begin
                    score(c, hg[k], a, b);
                    if (a != ha[k] || b != hb[k]) ok = 1'b0;
                end
                if (ok) return c;
            end
        end
        return -1;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic give_fb(input int a, input int b);
        fb_a     = 3'(a);
        fb_b     = 3'(b);
        fb_valid = 1'b1;
        tick();
        fb_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (guess_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_fail(input int limit, output int n);
        n = 0;
        while (fail !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Plays a full game against the given secret, scoring guesses with the model.
    task automatic play_game(input int secret);
        int n;
        int a;
        int b;
        int exp_g;
        hg.delete();
        ha.delete();
        hb.delete();
        pulse_start();
        for (int t = 0; t < 8; t++) begin
            exp_g = model_next();
            wait_valid(12000, n);
            check("guess_valid", guess_valid, 1);
            if (guess_valid !== 1'b1) return;
            if (t == 0) check("first_latency", n, 1);
            check("guess", guess, to_bcd(exp_g));
            check("turns", turns, t + 1);
            score(exp_g, secret, a, b);
            give_fb(a, b);
            if (a == 4) begin
                check("solved", solved, 1);
                check("solved_turns", turns, t + 1);
                check("solved_busy", busy, 0);
                check("solved_fail", fail, 0);
                return;
            end
            hg.push_back(exp_g);
            ha.push_back(a);
            hb.push_back(b);
            if (hg.size() == 8) begin
                check("turns_fail", fail, 1);
                check("turns_fail_code", fail_code, 3);
                return;
            end
            check("resume_busy", busy, 1);
            check("resume_not_valid", guess_valid, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int pool[10];
        int tmp;
        int r;
        int secret;

        // reset state
        tick();
        tick();
        check("rst_guess", guess, 0);
        check("rst_valid", guess_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_turns", turns, 0);
        check("rst_solved", solved, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_code", fail_code, 0);
        reset_n = 1'b1;
        tick();

        // directed targets
        play_game(123);
        play_game(4567);
        play_game(1032);

        // start together with abort from SOLVED: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_solved", solved, 0);
        check("abort_start_turns", turns, 0);

        // feedback in idle is ignored
        give_fb(4, 0);
        check("idle_fb_solved", solved, 0);
        check("idle_fb_busy", busy, 0);

        // illegal feedback 3A1B
        pulse_start();
        wait_valid(12000, n);
        check("ill_guess", guess, 16'h0123);
        give_fb(3, 1);
        check("ill_fail", fail, 1);
        check("ill_code", fail_code, 1);
        check("ill_turns", turns, 1);
        check("ill_valid", guess_valid, 0);

        // inconsistent feedback exhausts the search
        pulse_start();
        check("restart_fail_clr", fail, 0);
        check("restart_code_clr", fail_code, 0);
        wait_valid(12000, n);
        check("inc_guess0", guess, 16'h0123);
        give_fb(0, 0);
        wait_valid(12000, n);
        check("inc_guess1", guess, 16'h4567);
        give_fb(0, 0);
        wait_fail(10000, n);
        check("inc_fail", fail, 1);
        check("inc_code", fail_code, 2);
        check("inc_turns", turns, 2);

        // abort during search
        pulse_start();
        wait_valid(12000, n);
        give_fb(0, 0);
        tick();
        tick();
        check("abort_pre_busy", busy, 1);
        pulse_abort();
        check("abort_busy", busy, 0);
        check("abort_valid", guess_valid, 0);
        check("abort_guess", guess, 0);
        check("abort_turns", turns, 0);
        check("abort_fail", fail, 0);
        check("abort_solved", solved, 0);
        repeat (3) tick();
        check("abort_stays_idle", busy, 0);
        pulse_start();
        wait_valid(12000, n);
        check("after_abort_latency", n, 1);
        check("after_abort_guess", guess, 16'h0123);
        check("after_abort_turns", turns, 1);

        // asynchronous reset while waiting for feedback
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", guess_valid, 0);
        check("async_rst_turns", turns, 0);
        check("async_rst_guess", guess, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // randomized secrets
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 10; i++) pool[i] = i;
            for (int i = 9; i > 0; i--) begin
                r = int'($urandom_range(i, 0));
                tmp = pool[i];
                pool[i] = pool[r];
                pool[r] = tmp;
            end
            secret = pool[0] * 1000 + pool[1] * 100 + pool[2] * 10 + pool[3];
            play_game(secret);
        end

        // MAX_TURNS=2 instance: two non-winning feedbacks exhaust the turns
        s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        n = 0;
        while (d2_valid !== 1'b1 && n < 12000) begin
            tick();
            n++;
        end
        check("t2_valid0", d2_valid, 1);
        check("t2_guess0", d2_guess, 16'h0123);
        s2_fb_a = 3'd0;
        s2_fb_b = 3'd1;
        s2_fb_valid = 1'b1;
        tick();
        s2_fb_valid = 1'b0;
        n = 0;
        while (d2_valid !== 1'b1 && n < 12000) begin
            tick();
            n++;
        end
        check("t2_valid1", d2_valid, 1);
        s2_fb_valid = 1'b1;
        tick();
        s2_fb_valid = 1'b0;
        check("t2_fail", d2_fail, 1);
        check("t2_code", d2_fail_code, 3);
        check("t2_turns", d2_turns, 2);
        check("t2_busy", d2_busy, 0);
        check("t2_solved", d2_solved, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
